fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
Read-side engine for the team's synchronous FIFO. It drives the FIFO read enable, absorbs the FIFO's 1-cycle registered read latency, and presents the words as a valid/ready stream to downstream logic. It sustains 1 word/cycle and tracks transferred words. It sits between a sync FIFO instance and any consumer that may stall.

Parameters:
DATA_WIDTH, 4, word width; must equal the FIFO data width.
CNT_WIDTH, 16, width of the transferred-word counter.

Ports:
clk  input  1  clock, rising edge.
rstn  input  1  reset, asynchronous, active-low.
enable  input  1  1 = issue FIFO reads; 0 = stop issuing and drain.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_WIDTH  FIFO data output; valid the cycle after an accepted read.
fifo_rd_en  output  1  FIFO read enable (combinational).
m_valid  output  1  stream word valid.
m_data  output  DATA_WIDTH  stream word.
m_ready  input  1  downstream accepts the word.
busy  output  1  state != IDLE.
xfer_count  output  CNT_WIDTH  words accepted downstream since reset; wraps.

Behaviour:
- Reset (async, rstn=0): state IDLE, buffer empty (occ=0), inflight=0, m_valid=0, m_data=0, xfer_count=0, busy=0. fifo_rd_en=0 while rstn=0.
- Internal 2-entry skid buffer (head/tail). occ is 0..2. m_valid = (occ!=0). m_data = head entry, registered.
- inflight: a 1-bit register, set the cycle after fifo_rd_en=1 (the FIFO accepted the read because fifo_empty=0). When inflight=1, fifo_data is captured into the buffer on that clock edge.
- pop = m_valid && m_ready.
- fifo_rd_en = (state==RUN) && !fifo_empty && (occ + inflight - pop < 2).
  - The combinational path from m_ready to fifo_rd_en is intended.
  - It gives full throughput: steady state is occ=1, inflight=1, pop=1.
- Buffer never overflows; occ+inflight never exceeds 2. An overflow is a design error, and the bench asserts on it.
- Simultaneous capture and pop: head advances, the new word goes to the freed slot, occ is unchanged.
- Latency: read issued at edge N → word captured at edge N+1 → m_valid high after edge N+1 if the buffer was empty.
- Word ordering strictly preserved. No word is dropped or duplicated.
- m_data must be held stable while m_valid=1 and m_ready=0.
- xfer_count += 1 on every pop. Wraps from 2^CNT_WIDTH-1 to 0.
- FSM:
  - IDLE: enable=1 → RUN.
  - RUN: enable=0 → DRAIN if (occ!=0 or inflight); otherwise → IDLE.
  - DRAIN: no reads issued. Buffered and in-flight words are still delivered. Goes to IDLE when occ==0 and inflight==0 after the current edge. enable=1 in DRAIN → RUN (enable has priority).
- fifo_empty=1 in RUN: no read issued, no state change. Buffered words keep draining.
- Mid-operation reset: all buffered and in-flight words are discarded. The FIFO shares rstn, so its pointers clear together.

Decomposition:
- Package fifo_rd_pkg:
  - state enum typedef {IDLE, RUN, DRAIN}.
  - localparam BUF_DEPTH=2.
- Natural sub-module: stream_skid_buf. It holds the 2-entry buffer, occ, head/tail, and the push/pop logic.
- fifo_stream_reader holds the FSM, inflight, read-enable logic and the counter.
- Bench instantiates sync_fifo (depth 10, width 4) plus this block.

Test Plan:
1. Write 1,2,3,4,5 into the FIFO, enable=1, m_ready=1 → first m_valid 2 cycles after fifo_rd_en; then 5 back-to-back beats 1..5 with no gaps; xfer_count=5; busy drops after the FIFO drains and enable=0.
2. FIFO full (10 words 0..9), m_ready toggles 1,0,0,1 repeating → all 10 words in order, m_data stable while stalled, occ never >2, fifo_rd_en never high with occ+inflight-pop=2.
3. 8 words queued, deassert enable after 3 beats → DRAIN delivers the buffered/in-flight words (≤2 extra), then IDLE; remaining words stay in the FIFO (not empty); re-enable → rest delivered in order.
4. enable=1 with FIFO empty for 20 cycles → fifo_rd_en=0, m_valid=0, state stays RUN; a single write of 0xA → m_valid with m_data=0xA.
5. Pulse rstn=0 mid-stream with m_valid=1, occ=2 → m_valid=0, xfer_count=0, state IDLE immediately (asynchronous); no stale word appears after reset.
6. CNT_WIDTH=4, stream 17 words → xfer_count reads 1 after the 17th beat (wrap).

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_pkg : shared types and constants for the FIFO stream reader
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stream_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf : 2-entry circular skid buffer presenting a valid/ready head
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic                  r_head;
  logic [1:0]            r_occ;
  logic                  w_tail;

  // With two slots, tail is head offset by occ mod 2; a full buffer's tail
  // is the head slot, which is exactly the slot freed by a concurrent pop.
  assign w_tail  = r_head ^ r_occ[0];
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_head];
  assign o_occ   = r_occ;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem  <= '{default: '0};
      r_head <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (i_push) r_mem[w_tail] <= i_push_data;
      if (i_pop)  r_head        <= ~r_head;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with registered read data (1-cycle latency)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_do_wr = i_wr_en && !o_full;
  assign w_do_rd = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      o_rd_data <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_rd) begin
        o_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_do_wr) - CNT_W'(w_do_rd);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader : sync-FIFO read engine exposing a valid/ready stream
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  input  logic                  i_m_ready,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_xfer_count
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_xfer;
  logic [1:0]           w_occ;
  logic                 w_valid;
  logic                 w_pop;
  logic [2:0]           w_level;

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (r_inflight),
    .i_push_data(i_fifo_data),
    .i_pop      (w_pop),
    .o_valid    (w_valid),
    .o_data     (o_m_data),
    .o_occ      (w_occ)
  );

  assign w_pop     = w_valid && i_m_ready;
  // Buffer occupancy after this edge; a new read is allowed only while it
  // leaves a free slot for the word that read will return.
  assign w_level      = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign o_fifo_rd_en = (r_state == RUN) && !i_fifo_empty && (w_level < 3'd2);

  assign o_m_valid    = w_valid;
  assign o_busy       = (r_state != IDLE);
  assign o_xfer_count = r_xfer;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (i_enable) w_state_nxt = RUN;
      RUN:   if (!i_enable) w_state_nxt = (w_level != 3'd0 || o_fifo_rd_en) ? DRAIN : IDLE;
      DRAIN: begin
        if (i_enable)              w_state_nxt = RUN;
        else if (w_level == 3'd0)  w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_xfer     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= o_fifo_rd_en;
      if (w_pop) r_xfer <= r_xfer + CNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire
